modulo_demux_hs: RTL and testbench
==================================

Name: modulo_demux_hs

Overview:
- Parametrised, registered 1:N demultiplexer with valid/ready handshake on the input and on every output channel.
- Routes each accepted input word to the channel given by a select field.
- Each channel has a single-entry output register.
- Successor to the team's fixed 1:16 combinational demux, adding:
  - generic channel count and data width
  - back-pressure
  - out-of-range select detection
  - optional broadcast

Parameters:
N_CH, 16, number of output channels (2..256; need not be a power of two)
DATA_W, 8, payload width in bits
SEL_W, 4, select width; must satisfy 2^SEL_W >= N_CH
ERRC_W, 8, width of saturating error counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; when 0 no input is accepted
in_valid  in  1  input word valid
in_ready  out  1  input can be accepted this cycle (combinational)
in_sel  in  SEL_W  destination channel index
in_data  in  DATA_W  input payload
out_valid  out  N_CH  per-channel output valid, bit k = channel k
out_ready  in  N_CH  per-channel sink ready
out_data  out  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
err  out  1  one-cycle pulse: out-of-range select was accepted
err_cnt  out  ERRC_W  saturating count of out-of-range accepts

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous, active-low, and takes effect immediately.
- Reset values:
  - out_valid = 0
  - out_data = 0
  - err = 0
  - err_cnt = 0
  - Reset mid-operation discards all buffered words.
  - First acceptance is possible in the first cycle after rst_n deasserts.
- Per-channel state: occupied flag v[k] (drives out_valid[k]) and data register d[k].
- Channel acceptance: can_acc[k] = !v[k] | out_ready[k]. Same-cycle drain and refill is allowed.
- in_ready:
  - = en & can_acc[in_sel] when in_sel < N_CH
  - = en when in_sel >= N_CH
  - Depends combinationally on in_sel, en, v and out_ready; it does not depend on in_valid.
- Input transfer: occurs when in_valid & in_ready.
  - Valid select: on that edge d[in_sel] <= in_data and v[in_sel] <= 1.
  - Out-of-range select: the word is discarded, no channel changes, err = 1 next cycle, and err_cnt increments (holds at 2^ERRC_W-1).
- Output transfer on channel k: occurs when v[k] & out_ready[k]. v[k] clears unless refilled on the same edge.
- Simultaneous drain and fill on the same channel: v[k] stays 1 and d[k] takes the new word.
- Output stability: while v[k] & !out_ready[k], d[k] and v[k] hold.
- Unselected channels are unaffected by input transfers and drain independently.
- Latency: 1 cycle from input acceptance to out_valid.
- Throughput: 1 word/cycle aggregate; 1 word/cycle per channel when the sink is always ready.
- en = 0: in_ready = 0. Outputs keep draining normally; err and err_cnt are not affected.
- in_valid deasserted: no state change apart from output drains; err is 0 the following cycle.
- No combinational path from in_valid or in_data to any output.

Optional Feature:
- Macro: MODULO_DEMUX_BROADCAST_EN
- When defined:
  - Adds input port bcast (1 bit).
  - While bcast = 1: in_sel is ignored, in_ready = en & AND of can_acc[k] over all k, and an accepted word loads d[k] and sets v[k] for all N_CH channels on the same edge.
  - A broadcast accept never raises err.
  - While bcast = 0: behaviour is unchanged.
- When undefined: no bcast port; the behaviour above is the whole function.

Test Plan:
- Reset then route: N_CH=16, DATA_W=8, rst_n low with in_valid=1 -> all out_valid=0, out_data=0, err_cnt=0. Release reset; send 0xA5 to sel=9 with all out_ready=1 -> out_valid=0x0200 and out_data[79:72]=0xA5 one cycle later; cleared the cycle after.
- Back-pressure: out_ready[3]=0; send 0x11 to sel=3, then 0x22 to sel=3 -> in_ready=0 on the second word and d[3] holds 0x11. Raise out_ready[3] -> 0x22 is accepted in that same cycle, and out_valid[3] stays 1 carrying 0x22 next cycle.
- Streaming: one word per cycle cycling sel 0..15 with data 0x00..0x0F, all sinks ready -> in_ready constantly 1; each channel shows its word exactly one cycle after acceptance.
- Out-of-range: N_CH=12; send in_sel=13 three times -> in_ready=1, no out_valid change, err pulses 3 times, err_cnt=3. With ERRC_W=2 and 5 errors -> err_cnt saturates at 3.
- Enable and async reset: en=0 with in_valid=1 -> in_ready=0 and occupied channels still drain. Assert rst_n low mid-cycle while 5 channels are occupied -> out_valid=0 immediately, without waiting for a clock edge.
- Broadcast (macro defined): out_ready=all 1 except channel 7 occupied and stalled; bcast=1 with 0x3C -> in_ready=0. Release channel 7 -> all 16 channels show 0x3C next cycle and err stays 0.

Source files
------------

// File: rtl/modulo_demux_hs.sv
// modulo_demux_hs: registered 1:N demultiplexer with valid/ready handshakes.
// Each accepted input word is routed by in_sel into a single-entry register
// of the addressed channel. A select outside 0..N_CH-1 is accepted and
// dropped, pulsing err and bumping the saturating err_cnt.
// Optional feature macro: MODULO_DEMUX_BROADCAST_EN adds a bcast input that
// writes an accepted word into every channel at once.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                global enable for input acceptance
//   in_valid/in_ready input handshake (in_ready is combinational)
//   in_sel, in_data   destination channel and payload
//   bcast             broadcast request (only with MODULO_DEMUX_BROADCAST_EN)
//   out_valid/out_ready per-channel output handshake, bit k = channel k
//   out_data          channel k at [k*DATA_W +: DATA_W]
//   err, err_cnt      out-of-range pulse and saturating count
module modulo_demux_hs #(
  parameter int unsigned N_CH   = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned ERRC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [DATA_W-1:0]        in_data,
`ifdef MODULO_DEMUX_BROADCAST_EN
  input  logic                     bcast,
`endif
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic                     err,
  output logic [ERRC_W-1:0]        err_cnt
);

  localparam int unsigned DW_ALL = N_CH * DATA_W;
  localparam logic [ERRC_W-1:0] ERRC_MAX = '1;

  logic                w_bcast;
  logic [N_CH-1:0]     w_hit;
  logic                w_sel_ok;
  logic [N_CH-1:0]     w_can_acc;
  logic                w_acc;
  logic [N_CH-1:0]     w_v_nxt;
  logic [DW_ALL-1:0]   w_d_nxt;
  logic                w_err_nxt;
  logic [ERRC_W-1:0]   w_cnt_nxt;

  logic [N_CH-1:0]     r_v;
  logic [DW_ALL-1:0]   r_d;
  logic                r_err;
  logic [ERRC_W-1:0]   r_cnt;

`ifdef MODULO_DEMUX_BROADCAST_EN
  assign w_bcast = bcast;
`else
  assign w_bcast = 1'b0;
`endif

  // Select decode as a one-hot compare so no index can run past N_CH.
  always_comb begin
    w_hit = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_hit[k] = (32'(in_sel) == 32'(k));
    end
  end

  assign w_sel_ok  = |w_hit;
  assign w_can_acc = ~r_v | out_ready;

  // Input ready: never looks at in_valid; out-of-range selects are always taken.
  always_comb begin
    in_ready = 1'b0;
    if (w_bcast) begin
      in_ready = en & (&w_can_acc);
    end else if (w_sel_ok) begin
      in_ready = en & (|(w_hit & w_can_acc));
    end else begin
      in_ready = en;
    end
  end

  // Next state: drain first, then a load on the same edge overrides the drain.
  always_comb begin
    w_acc     = in_valid & in_ready;
    w_v_nxt   = r_v & ~out_ready;
    w_d_nxt   = r_d;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (w_acc && (w_bcast || w_hit[k])) begin
        w_v_nxt[k]                   = 1'b1;
        w_d_nxt[k*DATA_W +: DATA_W]  = in_data;
      end
    end
    w_err_nxt = w_acc & ~w_bcast & ~w_sel_ok;
    w_cnt_nxt = r_cnt;
    if (w_err_nxt && (r_cnt != ERRC_MAX)) begin
      w_cnt_nxt = r_cnt + ERRC_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_d   <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_v   <= w_v_nxt;
      r_d   <= w_d_nxt;
      r_err <= w_err_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign out_valid = r_v;
  assign out_data  = r_d;
  assign err       = r_err;
  assign err_cnt   = r_cnt;

endmodule

// File: tb/tb_modulo_demux_hs.sv
// Self-checking bench for modulo_demux_hs: a 16-channel instance checked
// every cycle against a behavioural model plus directed literal checks, and
// a 12-channel, 2-bit-counter instance for out-of-range and saturation.
module tb_modulo_demux_hs;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_sel;
  logic [7:0]   in_data;
  logic [15:0]  out_valid;
  logic [15:0]  out_ready;
  logic [127:0] out_data;
  logic         err;
  logic [7:0]   err_cnt;
  logic         bc;

  logic         s_valid;
  logic         s_ready;
  logic [3:0]   s_sel;
  logic [7:0]   s_data;
  logic [11:0]  s_ov;
  logic [11:0]  s_or;
  logic [95:0]  s_od;
  logic         s_err;
  logic [1:0]   s_cnt;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  modulo_demux_hs #(.N_CH(16), .DATA_W(8), .SEL_W(4), .ERRC_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
`ifdef MODULO_DEMUX_BROADCAST_EN
    .bcast(bc),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err), .err_cnt(err_cnt)
  );

  modulo_demux_hs #(.N_CH(12), .DATA_W(8), .SEL_W(4), .ERRC_W(2)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .en(1'b1),
    .in_valid(s_valid), .in_ready(s_ready), .in_sel(s_sel), .in_data(s_data),
`ifdef MODULO_DEMUX_BROADCAST_EN
    .bcast(1'b0),
`endif
    .out_valid(s_ov), .out_ready(s_or), .out_data(s_od),
    .err(s_err), .err_cnt(s_cnt)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model of the 16-channel instance: one slot per channel.
  logic [15:0] mv;
  logic [7:0]  md [16];
  logic        merr;
  logic [7:0]  mcnt;

  function automatic logic exp_ready();
    if (!en) return 1'b0;
    if (bc) return &(~mv | out_ready);
    if (int'(in_sel) < 16) return !mv[in_sel] || out_ready[in_sel];
    return 1'b1;
  endfunction

  function automatic logic [127:0] mflat();
    logic [127:0] f;
    f = '0;
    for (int k = 0; k < 16; k++) f[k*8 +: 8] = md[k];
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv   <= '0;
      for (int k = 0; k < 16; k++) md[k] <= '0;
      merr <= 1'b0;
      mcnt <= '0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (in_valid && exp_ready() && (bc || int'(in_sel) == k)) begin
          mv[k] <= 1'b1;
          md[k] <= in_data;
        end else if (out_ready[k]) begin
          mv[k] <= 1'b0;
        end
      end
      merr <= in_valid && exp_ready() && !bc && int'(in_sel) >= 16;
      if (in_valid && exp_ready() && !bc && int'(in_sel) >= 16 && mcnt != 8'hFF)
        mcnt <= mcnt + 8'd1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_out_valid", 128'(out_valid), 128'(mv));
    chk("cmp_out_data", out_data, mflat());
    chk("cmp_err", 128'(err), 128'(merr));
    chk("cmp_err_cnt", 128'(err_cnt), 128'(mcnt));
    chk("cmp_in_ready", 128'(in_ready), 128'(exp_ready()));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; in_sel = 4'd9; in_data = 8'hA5;
    out_ready = '1; bc = 1'b0;
    s_valid = 1'b0; s_sel = '0; s_data = '0; s_or = '1;

    // Reset with in_valid high, then route one word.
    step(); step();
    chk("rst_out_valid", 128'(out_valid), 128'h0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_err_cnt", 128'(err_cnt), 128'h0);
    chk("rst_err", 128'(err), 128'h0);
    rst_n = 1'b1;
    step();
    chk("route_valid", 128'(out_valid), 128'h0200);
    chk("route_data", 128'(out_data[79:72]), 128'hA5);
    in_valid = 1'b0;
    step();
    chk("route_clear", 128'(out_valid), 128'h0);

    // Back-pressure on channel 3.
    out_ready = 16'hFFF7; in_valid = 1'b1; in_sel = 4'd3; in_data = 8'h11;
    step();
    in_data = 8'h22;
    #1 chk("bp_stall_ready", 128'(in_ready), 128'h0);
    step();
    chk("bp_hold_valid", 128'(out_valid[3]), 128'h1);
    chk("bp_hold_data", 128'(out_data[31:24]), 128'h11);
    out_ready = '1;
    #1 chk("bp_release_ready", 128'(in_ready), 128'h1);
    step();
    chk("bp_refill_valid", 128'(out_valid[3]), 128'h1);
    chk("bp_refill_data", 128'(out_data[31:24]), 128'h22);
    in_valid = 1'b0;
    step();
    chk("bp_drained", 128'(out_valid), 128'h0);

    // Streaming one word per cycle across all channels.
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_sel = 4'(i); in_data = 8'(i);
      #1 chk("stream_ready", 128'(in_ready), 128'h1);
      step();
      chk("stream_valid", 128'(out_valid), 128'(16'(1) << i));
      chk("stream_data", 128'(out_data[i*8 +: 8]), 128'(i));
    end
    in_valid = 1'b0;
    step();

    // Fill five stalled channels, disable, then async reset mid-cycle.
    out_ready = '0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_sel = 4'(2 * i); in_data = 8'(8'h40 + i);
      step();
    end
    chk("fill5_valid", 128'(out_valid), 128'h0155);
    chk("fill5_data8", 128'(out_data[71:64]), 128'h44);
    en = 1'b0; in_sel = 4'd1;
    #1 chk("en_off_ready", 128'(in_ready), 128'h0);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_valid", 128'(out_valid), 128'h0);
    chk("async_rst_data", out_data, 128'h0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1; en = 1'b1;

    // Outputs still drain while en is low; nothing is accepted.
    out_ready = '0; in_valid = 1'b1;
    in_sel = 4'd1; in_data = 8'h61; step();
    in_sel = 4'd2; in_data = 8'h62; step();
    chk("en_fill_valid", 128'(out_valid), 128'h0006);
    en = 1'b0; in_sel = 4'd5; out_ready = '1;
    #1 chk("en_off_ready2", 128'(in_ready), 128'h0);
    step();
    chk("en_off_drain", 128'(out_valid), 128'h0);
    chk("en_off_errcnt", 128'(err_cnt), 128'h0);
    in_valid = 1'b0; en = 1'b1;
    step();

`ifdef MODULO_DEMUX_BROADCAST_EN
    // Broadcast blocked by one stalled channel, then released.
    out_ready = '0; in_valid = 1'b1; in_sel = 4'd7; in_data = 8'h77;
    step();
    out_ready = 16'hFF7F; bc = 1'b1; in_data = 8'h3C;
    #1 chk("bc_stall_ready", 128'(in_ready), 128'h0);
    step();
    chk("bc_stall_valid", 128'(out_valid), 128'h0080);
    out_ready = '1;
    #1 chk("bc_ready", 128'(in_ready), 128'h1);
    step();
    chk("bc_all_valid", 128'(out_valid), 128'hFFFF);
    for (int k = 0; k < 16; k++) chk("bc_data", 128'(out_data[k*8 +: 8]), 128'h3C);
    chk("bc_no_err", 128'(err), 128'h0);
    in_valid = 1'b0; bc = 1'b0;
    step();
`endif

    // Out-of-range selects on the 12-channel instance with a 2-bit counter.
    s_valid = 1'b1; s_sel = 4'd13; s_data = 8'h99;
    for (int i = 0; i < 3; i++) begin
      #1 chk("oor_ready", 128'(s_ready), 128'h1);
      step();
      chk("oor_err_pulse", 128'(s_err), 128'h1);
    end
    chk("oor_cnt3", 128'(s_cnt), 128'h3);
    chk("oor_no_valid", 128'(s_ov), 128'h0);
    s_sel = 4'd12;
    step();
    chk("oor_sel12_err", 128'(s_err), 128'h1);
    s_sel = 4'd15;
    step();
    chk("oor_saturate", 128'(s_cnt), 128'h3);
    s_sel = 4'd11; s_data = 8'h5A;
    step();
    chk("ch11_valid", 128'(s_ov), 128'h800);
    chk("ch11_data", 128'(s_od[95:88]), 128'h5A);
    chk("ch11_no_err", 128'(s_err), 128'h0);
    s_valid = 1'b0;
    step();
    chk("idle_err", 128'(s_err), 128'h0);
    chk("idle_drained", 128'(s_ov), 128'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
